// File: rtl/window_3x3_if.sv
// Control, pixel-memory read port and window output of the 3x3 window generator.
// The generator side uses 'master'; the frame controller / memory / Sobel side uses 'slave'.
interface window_3x3_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [1:0]        size;
    logic [ADDR_W-1:0] Pixel_address;
    logic              rd_en;
    logic              pixel_in;
    logic [8:0]        window;
    logic              ValidResult;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, size, pixel_in,
        output Pixel_address, rd_en, window, ValidResult, busy, frame_done
    );

    modport slave (
        output start, size, pixel_in,
        input  Pixel_address, rd_en, window, ValidResult, busy, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster-scans a square 1-bpp image out of pixel memory and emits one 3x3 window
// per interior pixel, using two cascaded line buffers tapped at the image width.
module window_3x3_gen #(
    parameter int MAX_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    window_3x3_if.master bus
);
    localparam int CW = $clog2(MAX_W);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     n_m1_q, n_m1_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flush_q, flush_d;

    logic              tag_v_q, tag_v_d;
    logic [CW-1:0]     pr_q, pr_d;
    logic [CW-1:0]     pc_q, pc_d;
    logic [MAX_W-1:0]  lb0_q, lb0_d;
    logic [MAX_W-1:0]  lb1_q, lb1_d;
    logic [8:0]        win_q, win_d;
    logic [8:0]        window_q, window_d;
    logic              valid_q, valid_d;

    logic              lb0_tap, lb1_tap;
    logic [2:0]        new_col;
    logic [8:0]        win_shift;

    // Frame sequencer: one read per FETCH cycle, then two cycles to drain the pipeline.
    always_comb begin
        state_d = state_q;
        n_m1_d  = n_m1_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.size)
                        2'b00:   n_m1_d = CW'(3);
                        2'b01:   n_m1_d = CW'(7);
                        default: n_m1_d = CW'(MAX_W - 1);
                    endcase
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                    flush_d = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                addr_d = addr_q + ADDR_W'(1);
                if (col_q == n_m1_q) begin
                    col_d = '0;
                    row_d = row_q + CW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if ((row_q == n_m1_q) && (col_q == n_m1_q)) begin
                    flush_d = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lb0_tap = lb0_q[n_m1_q];
    assign lb1_tap = lb1_q[n_m1_q];
    assign new_col = {bus.pixel_in, lb0_tap, lb1_tap};

    // Each window row moves one column left; the incoming column lands in column 2.
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        assign win_shift[3*gi]     = win_q[3*gi+1];
        assign win_shift[3*gi + 1] = win_q[3*gi+2];
        assign win_shift[3*gi + 2] = new_col[gi];
    end

    always_comb begin
        tag_v_d  = (state_q == FETCH);
        pr_d     = row_q;
        pc_d     = col_q;
        lb0_d    = lb0_q;
        lb1_d    = lb1_q;
        win_d    = win_q;
        window_d = window_q;
        valid_d  = 1'b0;
        if (tag_v_q) begin
            lb0_d = {lb0_q[MAX_W-2:0], bus.pixel_in};
            lb1_d = {lb1_q[MAX_W-2:0], lb0_tap};
            win_d = win_shift;
            // Columns 0/1 would see the previous row's tail, so only interior pixels publish.
            if ((pr_q >= CW'(2)) && (pc_q >= CW'(2))) begin
                valid_d  = 1'b1;
                window_d = win_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_m1_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            flush_q  <= 1'b0;
            tag_v_q  <= 1'b0;
            pr_q     <= '0;
            pc_q     <= '0;
            lb0_q    <= '0;
            lb1_q    <= '0;
            win_q    <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_m1_q   <= n_m1_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            flush_q  <= flush_d;
            tag_v_q  <= tag_v_d;
            pr_q     <= pr_d;
            pc_q     <= pc_d;
            lb0_q    <= lb0_d;
            lb1_q    <= lb1_d;
            win_q    <= win_d;
            window_q <= window_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.rd_en         = (state_q == FETCH);
    assign bus.Pixel_address = (state_q == FETCH) ? addr_q : '0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.frame_done    = (state_q == DONE);
    assign bus.window        = window_q;
    assign bus.ValidResult   = valid_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench: frame table plus hand sequences for reset, restart and
// mid-frame abort; windows compared against a direct neighbourhood model.
module tb_window_3x3_gen;
    localparam int MAX_W  = 16;
    localparam int ADDR_W = 8;
    localparam int P_CHK = 0, P_ONE = 1, P_SGL = 2, P_RND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_3x3_if #(.ADDR_W(ADDR_W)) bus_if ();

    window_3x3_gen #(.MAX_W(MAX_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    logic mem [0:255];
    logic img [0:15][0:15];

    // Pixel memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus_if.rd_en) bus_if.pixel_in <= mem[bus_if.Pixel_address];
    end

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [8:0] exp_w[$];
    logic [8:0] act_w[$];
    int         act_wc[$];
    int         rd_a[$];
    int         rd_c[$];
    int         done_c[$];
    int         busy_n;

    typedef struct {
        logic [1:0] sz;
        int         pat;
        int         n;
        int         nwin;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic fill(input int pat, input int n);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (pat)
                    P_CHK:   img[r][c] = 1'(r ^ c);
                    P_ONE:   img[r][c] = 1'b1;
                    P_SGL:   img[r][c] = (r == 5 && c == 7);
                    default: img[r][c] = 1'($urandom_range(0, 1));
                endcase
            end
        end
        for (int a = 0; a < 256; a++) mem[a] = 1'b0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                mem[r*n + c] = img[r][c];
    endtask

    // Reference: every interior centre in raster order, bit 3*dr+dc = image(r-1+dr, c-1+dc).
    task automatic build_model(input int n);
        logic [8:0] w;
        exp_w.delete();
        for (int r = 1; r <= n - 2; r++) begin
            for (int c = 1; c <= n - 2; c++) begin
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w[3*dr + dc] = img[r-1+dr][c-1+dc];
                exp_w.push_back(w);
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] sz, input int pat, input int n,
                             input int nwin, input int poke);
        int post;
        int bad;
        int nz;
        fill(pat, n);
        build_model(n);
        act_w.delete(); act_wc.delete(); rd_a.delete(); rd_c.delete(); done_c.delete();
        busy_n = 0;
        post   = 0;
        @(negedge clk);
        bus_if.size  = sz;
        bus_if.start = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (bus_if.rd_en) begin
                rd_a.push_back(int'(bus_if.Pixel_address));
                rd_c.push_back(k);
            end
            if (bus_if.ValidResult) begin
                act_w.push_back(bus_if.window);
                act_wc.push_back(k);
            end
            if (bus_if.busy) busy_n++;
            if (bus_if.frame_done) done_c.push_back(k);
            bus_if.start = (k == poke);
            if (k == poke) bus_if.size = 2'b00;
            if (done_c.size() > 0) post++;
            if (post == 4) break;
        end
        bus_if.start = 1'b0;

        check("frame_done_count", done_c.size(), 1);
        check("read_count", rd_a.size(), n*n);
        bad = 0;
        foreach (rd_a[i]) if (rd_a[i] != i) bad++;
        check("address_sequence_errors", bad, 0);
        if (rd_a.size() > 0) begin
            check("last_address", rd_a[rd_a.size()-1], n*n - 1);
            check("read_span_no_gaps", rd_c[rd_c.size()-1] - rd_c[0], n*n - 1);
        end
        check("busy_cycles", busy_n, n*n + 3);
        check("window_count", act_w.size(), nwin);
        for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
            check($sformatf("window[%0d]", i), int'(act_w[i]), int'(exp_w[i]));
        if (act_wc.size() > 0 && rd_c.size() > 2*n + 2)
            check("first_window_latency", act_wc[0] - rd_c[2*n + 2], 2);
        if (act_wc.size() > 0 && done_c.size() > 0)
            check("done_after_last_window", done_c[0] - act_wc[act_wc.size()-1], 1);
        if (pat == P_CHK && act_w.size() > 0)
            check("checker_first_window", int'(act_w[0]), int'(9'b010101010));
        if (pat == P_SGL) begin
            nz = 0;
            foreach (act_w[i]) if (act_w[i] != 9'd0) nz++;
            check("single_nonzero_windows", nz, 9);
            if (act_w.size() > 62)
                check("single_centre_window", int'(act_w[62]), int'(9'b000010000));
        end
        $display("frame N=%0d size=%0b pattern=%0d reads=%0d windows=%0d done=%0d busy=%0d",
                 n, sz, pat, rd_a.size(), act_w.size(), done_c.size(), busy_n);
    endtask

    initial begin
        int cnt;
        int seen;
        bus_if.start = 1'b0;
        bus_if.size  = 2'b00;

        tbl[0] = '{sz: 2'b00, pat: P_CHK, n: 4,  nwin: 4};
        tbl[1] = '{sz: 2'b01, pat: P_ONE, n: 8,  nwin: 36};
        tbl[2] = '{sz: 2'b10, pat: P_SGL, n: 16, nwin: 196};
        tbl[3] = '{sz: 2'b11, pat: P_RND, n: 16, nwin: 196};
        tbl[4] = '{sz: 2'b00, pat: P_RND, n: 4,  nwin: 4};
        tbl[5] = '{sz: 2'b01, pat: P_RND, n: 8,  nwin: 36};

        // Reset held with start high: everything quiet.
        rst_n = 1'b0;
        bus_if.start = 1'b1;
        bus_if.size  = 2'b10;
        repeat (3) @(negedge clk);
        check("reset_rd_en", int'(bus_if.rd_en), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        check("reset_valid", int'(bus_if.ValidResult), 0);
        check("reset_window", int'(bus_if.window), 0);
        check("reset_frame_done", int'(bus_if.frame_done), 0);
        check("reset_address", int'(bus_if.Pixel_address), 0);
        rst_n = 1'b1;
        bus_if.start = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(bus_if.rd_en) + int'(bus_if.busy);
        end
        check("idle_without_start", seen, 0);
        $display("reset sequence done");

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].sz, tbl[i].pat, tbl[i].n, tbl[i].nwin, -1);

        // Start and size change during FETCH are ignored.
        run_frame(2'b01, P_RND, 8, 36, 10);

        // Start while in DONE is dropped; start in the following IDLE cycle is taken.
        fill(P_RND, 4);
        @(negedge clk);
        bus_if.size  = 2'b00;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus_if.frame_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("done_reached", seen, 1);
        bus_if.start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", int'(bus_if.busy), 0);
        @(negedge clk);
        check("start_in_idle_accepted", int'(bus_if.busy), 1);
        bus_if.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_if.frame_done) begin
                seen = 1;
                break;
            end
        end
        check("restart_frame_done", seen, 1);
        $display("done/start overlap sequence done");

        // Abort a 16x16 frame at its 20th read.
        fill(P_RND, 16);
        @(negedge clk);
        bus_if.size  = 2'b10;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus_if.rd_en) cnt++;
            if (cnt == 20) break;
            @(negedge clk);
        end
        check("abort_read_count", cnt, 20);
        rst_n = 1'b0;
        #1;
        check("abort_rd_en", int'(bus_if.rd_en), 0);
        check("abort_busy", int'(bus_if.busy), 0);
        check("abort_valid", int'(bus_if.ValidResult), 0);
        check("abort_window", int'(bus_if.window), 0);
        check("abort_address", int'(bus_if.Pixel_address), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(bus_if.frame_done) + int'(bus_if.busy);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            seen += int'(bus_if.frame_done) + int'(bus_if.busy);
        end
        check("abort_no_done_no_busy", seen, 0);
        $display("mid-frame reset sequence done");
        run_frame(2'b00, P_RND, 4, 4, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
